// File: rtl/me3drs_pkg.sv
// Shared constants and types for the 3DRS search-window receive path.
// Beat layout: each 64-bit beat carries rows a, a+22, a+44, a+66 and their odd neighbours (a=2*beat).
package me3drs_pkg;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned WIN       = 88;
  localparam int unsigned STEP      = 16;
  localparam int unsigned BLK       = 16;
  localparam int unsigned BEATS_COL = 11;
  localparam int unsigned LANES     = 8;

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t [WIN-1:0]   col_t;

  localparam int unsigned ROW_OFF0 = 0;
  localparam int unsigned ROW_OFF1 = 22;
  localparam int unsigned ROW_OFF2 = 44;
  localparam int unsigned ROW_OFF3 = 66;
  localparam int unsigned ROW_ODD  = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} swrx_state_e;

  // Lanes 4..7 carry the even rows, lanes 0..3 the following odd rows.
  function automatic logic [6:0] lane_row(input logic [3:0] beat, input int unsigned lane);
    int unsigned off;
    int unsigned row;
    case (lane % 4)
      0:       off = ROW_OFF0;
      1:       off = ROW_OFF1;
      2:       off = ROW_OFF2;
      default: off = ROW_OFF3;
    endcase
    if (lane < 4) off = off + ROW_ODD;
    row = {28'd0, beat} * 2 + off;
    return row[6:0];
  endfunction
endpackage

// File: rtl/swrx_col_store.sv
// Search-window pixel storage: one column per entry, 8-lane beat write,
// combinational 16-row read slice with rows clipped at the bottom of the window.
module swrx_col_store
  import me3drs_pkg::*;
(
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [6:0]                i_wcol,
  input  logic [LANES-1:0][6:0]     i_wrow,
  input  logic [LANES*PIX_W-1:0]    i_wdata,
  input  logic [6:0]                i_rcol,
  input  logic [6:0]                i_rrow,
  output logic [BLK*PIX_W-1:0]      o_rdata
);
  col_t r_mem [WIN];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        r_mem[i_wcol][i_wrow[l]] <= i_wdata[l*PIX_W +: PIX_W];
      end
    end
  end

  always_comb begin
    logic [7:0] w_row;
    w_row   = '0;
    o_rdata = '0;
    for (int unsigned i = 0; i < BLK; i++) begin
      w_row = {1'b0, i_rrow} + 8'(i);
      if (w_row > 8'(WIN-1)) w_row = 8'(WIN-1);
      o_rdata[(BLK-1-i)*PIX_W +: PIX_W] = r_mem[i_rcol][w_row[6:0]];
    end
  end
endmodule

// File: rtl/search_window_rx.sv
// Search-window load receiver: load FSM, column/beat counters, circular column base, read port.
// Optional SWRX_ERRCHK_EN enables the sticky err flag (abort and read-row overrange).
module search_window_rx
  import me3drs_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          row_start,
  input  logic          search_WE,
  input  logic [63:0]   search_data_in,
  input  logic          rd_en,
  input  logic [6:0]    rd_row,
  input  logic [6:0]    rd_col,
  output logic [127:0]  rd_data,
  output logic          rd_valid,
  output logic          window_valid,
  output logic          srcfilled,
  output logic          err
);
  swrx_state_e r_state;
  logic [6:0]   r_col;
  logic [3:0]   r_beat;
  logic [6:0]   r_base;
  logic         r_full_mode;
  logic         r_window_valid;
  logic         r_srcfilled;
  logic         r_rd_valid;
  logic [127:0] r_rd_data;

  logic                  w_last_old, w_in_load, w_abort, w_new, w_full, w_complete;
  logic [6:0]            w_col, w_wcol, w_rcol, w_base_next;
  logic [3:0]            w_beat;
  logic [7:0]            w_wsum, w_rsum, w_bsum;
  logic [LANES-1:0][6:0] w_wrow;
  logic [127:0]          w_rdata;

  // A beat arriving outside LOAD, or with an aborting row_start, is beat 0 of a new load.
  always_comb begin
    w_in_load  = (r_state == ST_LOAD);
    w_last_old = (r_col == (r_full_mode ? 7'(WIN-1) : 7'(STEP-1))) &&
                 (r_beat == 4'(BEATS_COL-1));
    w_abort    = w_in_load && row_start && !(search_WE && w_last_old);
    w_new      = !w_in_load || w_abort;
    w_full     = w_new ? (r_full_mode | row_start) : r_full_mode;
    w_col      = w_new ? '0 : r_col;
    w_beat     = w_new ? '0 : r_beat;
    w_complete = search_WE && w_in_load && w_last_old;
    w_wsum     = {1'b0, r_base} + {1'b0, w_col};
    w_wcol     = w_full ? w_col
               : ((w_wsum >= 8'(WIN)) ? 7'(w_wsum - 8'(WIN)) : w_wsum[6:0]);
    w_bsum     = {1'b0, r_base} + 8'(STEP);
    w_base_next = (w_bsum >= 8'(WIN)) ? 7'(w_bsum - 8'(WIN)) : w_bsum[6:0];
    w_rsum     = {1'b0, rd_col} + {1'b0, r_base};
    w_rcol     = (w_rsum >= 8'(WIN)) ? 7'(w_rsum - 8'(WIN)) : w_rsum[6:0];
    w_wrow     = '0;
    for (int unsigned l = 0; l < LANES; l++) w_wrow[l] = lane_row(w_beat, l);
  end

  swrx_col_store u_store (
    .clk     (clk),
    .i_we    (search_WE),
    .i_wcol  (w_wcol),
    .i_wrow  (w_wrow),
    .i_wdata (search_data_in),
    .i_rcol  (w_rcol),
    .i_rrow  (rd_row),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_col          <= '0;
      r_beat         <= '0;
      r_base         <= '0;
      r_full_mode    <= 1'b1;
      r_window_valid <= 1'b0;
      r_srcfilled    <= 1'b0;
      r_rd_valid     <= 1'b0;
      r_rd_data      <= '0;
    end else begin
      r_srcfilled <= 1'b0;
      if (search_WE) begin
        if (w_complete) begin
          r_state        <= ST_DONE;
          r_srcfilled    <= 1'b1;
          r_window_valid <= 1'b1;
          r_col          <= '0;
          r_beat         <= '0;
          r_base         <= r_full_mode ? '0 : w_base_next;
          // row_start on the final beat arms the next load as full
          r_full_mode    <= row_start;
        end else begin
          r_state        <= ST_LOAD;
          r_window_valid <= 1'b0;
          r_full_mode    <= w_full;
          if (w_beat == 4'(BEATS_COL-1)) begin
            r_beat <= '0;
            r_col  <= w_col + 7'd1;
          end else begin
            r_beat <= w_beat + 4'd1;
            r_col  <= w_col;
          end
        end
      end else begin
        if (row_start) r_full_mode <= 1'b1;
        if (w_abort) begin
          r_state <= ST_IDLE;
          r_col   <= '0;
          r_beat  <= '0;
        end else if (r_state == ST_DONE) begin
          r_state <= ST_IDLE;
        end
      end
      if (rd_en && r_window_valid) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_rdata;
      end else begin
        r_rd_valid <= 1'b0;
      end
    end
  end

`ifdef SWRX_ERRCHK_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (!reset) r_err <= 1'b0;
    else if (w_abort || (rd_en && (rd_row > 7'(WIN-BLK)))) r_err <= 1'b1;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign window_valid = r_window_valid;
  assign srcfilled    = r_srcfilled;
endmodule

// File: tb/tb_search_window_rx.sv
// Bench for search_window_rx: random/pattern window loads checked against a logical-window model
// that slides 16 columns per incremental load.
module tb_search_window_rx;
  logic         clk = 1'b0;
  logic         reset, row_start, search_WE, rd_en;
  logic [63:0]  search_data_in;
  logic [6:0]   rd_row, rd_col;
  logic [127:0] rd_data;
  logic         rd_valid, window_valid, srcfilled, err;

  always #5 clk = ~clk;

  search_window_rx dut (
    .clk(clk), .reset(reset), .row_start(row_start), .search_WE(search_WE),
    .search_data_in(search_data_in), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data), .rd_valid(rd_valid), .window_valid(window_valid),
    .srcfilled(srcfilled), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int fill_cnt = 0;
  logic [7:0]   wm [88][88];   // logical window [row][col]
  logic [7:0]   lb [88][88];   // columns of the load being sent [col][row]
  logic [127:0] last_rd;
  logic         exp_err;

`ifdef SWRX_ERRCHK_EN
  initial exp_err = 1'b1;
`else
  initial exp_err = 1'b0;
`endif

  always begin
    @(negedge clk);
    #1;
    if (srcfilled === 1'b1) fill_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] beat_word(int unsigned col, int unsigned k);
    int unsigned a;
    a = 2 * k;
    return {lb[col][a+66], lb[col][a+44], lb[col][a+22], lb[col][a],
            lb[col][a+67], lb[col][a+45], lb[col][a+23], lb[col][a+1]};
  endfunction

  function automatic logic [127:0] exp_read(int unsigned row, int unsigned col);
    logic [127:0] v;
    int unsigned r;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      r = (row + i > 87) ? 87 : row + i;
      v[127-8*i -: 8] = wm[r][col];
    end
    return v;
  endfunction

  task automatic fill_pattern(int unsigned ncols, int unsigned add);
    for (int unsigned c = 0; c < ncols; c++)
      for (int unsigned r = 0; r < 88; r++) lb[c][r] = 8'((r + c + add) & 255);
  endtask

  task automatic fill_random(int unsigned ncols);
    for (int unsigned c = 0; c < ncols; c++)
      for (int unsigned r = 0; r < 88; r++) lb[c][r] = 8'($urandom);
  endtask

  task automatic commit(bit full);
    for (int unsigned r = 0; r < 88; r++) begin
      if (full) begin
        for (int unsigned c = 0; c < 88; c++) wm[r][c] = lb[c][r];
      end else begin
        for (int unsigned c = 0; c < 72; c++) wm[r][c] = wm[r][c+16];
        for (int unsigned c = 72; c < 88; c++) wm[r][c] = lb[c-72][r];
      end
    end
  endtask

  task automatic stream(int unsigned b0, int unsigned b1, int unsigned gap, bit rs_first, bit rs_last);
    for (int unsigned b = b0; b < b1; b++) begin
      @(negedge clk);
      search_WE      = 1'b1;
      search_data_in = beat_word(b / 11, b % 11);
      row_start      = (rs_first && b == b0) || (rs_last && b == b1 - 1);
      if (b != b1 - 1) begin
        for (int unsigned g = 0; g < gap; g++) begin
          @(negedge clk);
          search_WE      = 1'b0;
          row_start      = 1'b0;
          search_data_in = {$urandom, $urandom};
        end
      end
    end
  endtask

  task automatic idle(int unsigned n);
    repeat (n) begin
      @(negedge clk);
      search_WE = 1'b0;
      row_start = 1'b0;
      rd_en     = 1'b0;
    end
  endtask

  task automatic do_read(int unsigned row, int unsigned col, output logic v, output logic [127:0] d);
    @(negedge clk);
    search_WE = 1'b0;
    row_start = 1'b0;
    rd_en     = 1'b1;
    rd_row    = 7'(row);
    rd_col    = 7'(col);
    @(negedge clk);
    rd_en = 1'b0;
    v = rd_valid;
    d = rd_data;
  endtask

  task automatic test_reset();
    reset = 1'b0; row_start = 1'b0; search_WE = 1'b0; rd_en = 1'b0;
    search_data_in = '0; rd_row = '0; rd_col = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (window_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wv got %b exp 0", window_valid); end
    n_tests++; if (srcfilled !== 1'b0) begin n_fail++; $display("FAIL reset_sf got %b exp 0", srcfilled); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got %b exp 0", rd_valid); end
    n_tests++; if (rd_data !== 128'd0) begin n_fail++; $display("FAIL reset_rd got %h exp 0", rd_data); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
    reset = 1'b1;
    last_rd = '0;
  endtask

  task automatic test_full_load();
    logic v; logic [127:0] d; int f0;
    fill_pattern(88, 0);
    @(negedge clk); row_start = 1'b1;
    @(negedge clk); row_start = 1'b0;
    f0 = fill_cnt;
    stream(0, 968, 0, 0, 0);
    @(negedge clk); search_WE = 1'b0;
    n_tests++; if (srcfilled !== 1'b1 || window_valid !== 1'b1) begin n_fail++; $display("FAIL full_done got sf=%b wv=%b exp 1 1", srcfilled, window_valid); end
    commit(1);
    @(negedge clk);
    n_tests++; if (srcfilled !== 1'b0) begin n_fail++; $display("FAIL full_pulse got %b exp 0", srcfilled); end
    idle(1);
    n_tests++; if (fill_cnt != f0 + 1) begin n_fail++; $display("FAIL full_cnt got %0d exp %0d", fill_cnt, f0 + 1); end
    do_read(0, 0, v, d);
    n_tests++; if (v !== 1'b1 || d !== 128'h000102030405060708090A0B0C0D0E0F) begin n_fail++; $display("FAIL full_rd00 got v=%b %h exp 000102..0F", v, d); end
    do_read(72, 87, v, d);
    n_tests++; if (d !== 128'h9FA0A1A2A3A4A5A6A7A8A9AAABACADAE || d !== exp_read(72, 87)) begin n_fail++; $display("FAIL full_rd7287 got %h exp 9FA0..AE", d); end
    last_rd = d;
  endtask

  task automatic test_incremental();
    logic v; logic [127:0] d;
    fill_pattern(16, 16);
    stream(0, 176, 0, 0, 0);
    @(negedge clk); search_WE = 1'b0;
    n_tests++; if (srcfilled !== 1'b1) begin n_fail++; $display("FAIL inc_done got %b exp 1", srcfilled); end
    commit(0);
    do_read(0, 0, v, d);
    n_tests++; if (d !== 128'h101112131415161718191A1B1C1D1E1F) begin n_fail++; $display("FAIL inc_rd00 got %h exp 1011..1F", d); end
    do_read(0, 72, v, d);
    n_tests++; if (v !== 1'b1 || d !== exp_read(0, 72)) begin n_fail++; $display("FAIL inc_rd072 got v=%b %h exp %h", v, d, exp_read(0, 72)); end
    last_rd = d;
  endtask

  task automatic test_wrap();
    logic v; logic [127:0] d; int unsigned r, c;
    for (int i = 0; i < 6; i++) begin
      fill_random(16);
      stream(0, 176, 0, 0, 0);
      @(negedge clk); search_WE = 1'b0;
      n_tests++; if (srcfilled !== 1'b1) begin n_fail++; $display("FAIL wrap%0d_done got %b exp 1", i, srcfilled); end
      commit(0);
      do_read(5, 3, v, d);
      n_tests++; if (d !== exp_read(5, 3)) begin n_fail++; $display("FAIL wrap%0d_rd53 got %h exp %h", i, d, exp_read(5, 3)); end
      r = $urandom_range(72, 0); c = $urandom_range(87, 0);
      do_read(r, c, v, d);
      n_tests++; if (d !== exp_read(r, c)) begin n_fail++; $display("FAIL wrap%0d_rd(%0d,%0d) got %h exp %h", i, r, c, d, exp_read(r, c)); end
      last_rd = d;
    end
  endtask

  task automatic test_duty();
    logic v; logic [127:0] d; int f0; int unsigned r, c;
    fill_random(88);
    f0 = fill_cnt;
    stream(0, 967, 2, 1, 0);
    idle(2);
    n_tests++; if (fill_cnt != f0 || window_valid !== 1'b0) begin n_fail++; $display("FAIL duty_early got cnt=%0d wv=%b exp %0d 0", fill_cnt, window_valid, f0); end
    stream(967, 968, 0, 0, 0);
    @(negedge clk); search_WE = 1'b0;
    n_tests++; if (srcfilled !== 1'b1) begin n_fail++; $display("FAIL duty_done got %b exp 1", srcfilled); end
    commit(1);
    for (int i = 0; i < 3; i++) begin
      r = $urandom_range(72, 0); c = $urandom_range(87, 0);
      do_read(r, c, v, d);
      n_tests++; if (d !== exp_read(r, c)) begin n_fail++; $display("FAIL duty_rd(%0d,%0d) got %h exp %h", r, c, d, exp_read(r, c)); end
      last_rd = d;
    end
  endtask

  task automatic test_back_to_back();
    logic v; logic [127:0] d; int f0; int unsigned r, c;
    f0 = fill_cnt;
    fill_random(16);
    stream(0, 176, 0, 0, 1);
    commit(0);
    fill_random(88);
    stream(0, 968, 0, 0, 0);
    @(negedge clk); search_WE = 1'b0;
    n_tests++; if (srcfilled !== 1'b1) begin n_fail++; $display("FAIL b2b_done got %b exp 1", srcfilled); end
    commit(1);
    idle(2);
    n_tests++; if (fill_cnt != f0 + 2) begin n_fail++; $display("FAIL b2b_cnt got %0d exp %0d", fill_cnt, f0 + 2); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err got %b exp 0", err); end
    for (int i = 0; i < 2; i++) begin
      r = $urandom_range(72, 0); c = $urandom_range(87, 0);
      do_read(r, c, v, d);
      n_tests++; if (d !== exp_read(r, c)) begin n_fail++; $display("FAIL b2b_rd(%0d,%0d) got %h exp %h", r, c, d, exp_read(r, c)); end
      last_rd = d;
    end
  endtask

  task automatic test_idle_read_clip();
    logic v; logic [127:0] d; int unsigned c;
    fill_random(88);
    stream(0, 1, 0, 1, 0);
    do_read(0, 0, v, d);
    n_tests++; if (v !== 1'b0 || d !== last_rd || window_valid !== 1'b0) begin n_fail++; $display("FAIL inv_rd got v=%b wv=%b %h exp v=0 wv=0 %h", v, window_valid, d, last_rd); end
    stream(1, 968, 0, 0, 0);
    @(negedge clk); search_WE = 1'b0;
    n_tests++; if (srcfilled !== 1'b1) begin n_fail++; $display("FAIL clip_done got %b exp 1", srcfilled); end
    commit(1);
    c = $urandom_range(87, 0);
    do_read(80, c, v, d);
    n_tests++; if (v !== 1'b1 || d !== exp_read(80, c)) begin n_fail++; $display("FAIL clip_rd(80,%0d) got v=%b %h exp %h", c, v, d, exp_read(80, c)); end
    n_tests++; if (err !== exp_err) begin n_fail++; $display("FAIL clip_err got %b exp %b", err, exp_err); end
    last_rd = d;
  endtask

  task automatic test_abort();
    logic v; logic [127:0] d; int f0; int unsigned r, c;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n_tests++; if (err !== 1'b0 || window_valid !== 1'b0) begin n_fail++; $display("FAIL rst2 got err=%b wv=%b exp 0 0", err, window_valid); end
    fill_random(88);
    stream(0, 500, 0, 0, 0);
    @(negedge clk); search_WE = 1'b0;
    n_tests++; if (err !== 1'b0 || window_valid !== 1'b0) begin n_fail++; $display("FAIL pre_abort got err=%b wv=%b exp 0 0", err, window_valid); end
    f0 = fill_cnt;
    fill_random(88);
    stream(0, 967, 0, 1, 0);
    @(negedge clk); search_WE = 1'b0;
    n_tests++; if (err !== exp_err || window_valid !== 1'b0 || fill_cnt != f0) begin n_fail++; $display("FAIL abort_mid got err=%b wv=%b cnt=%0d exp %b 0 %0d", err, window_valid, fill_cnt, exp_err, f0); end
    stream(967, 968, 0, 0, 0);
    @(negedge clk); search_WE = 1'b0;
    n_tests++; if (srcfilled !== 1'b1 || window_valid !== 1'b1) begin n_fail++; $display("FAIL abort_done got sf=%b wv=%b exp 1 1", srcfilled, window_valid); end
    commit(1);
    idle(2);
    n_tests++; if (fill_cnt != f0 + 1) begin n_fail++; $display("FAIL abort_cnt got %0d exp %0d", fill_cnt, f0 + 1); end
    for (int i = 0; i < 2; i++) begin
      r = $urandom_range(72, 0); c = $urandom_range(87, 0);
      do_read(r, c, v, d);
      n_tests++; if (d !== exp_read(r, c)) begin n_fail++; $display("FAIL abort_rd(%0d,%0d) got %h exp %h", r, c, d, exp_read(r, c)); end
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_incremental();
    test_wrap();
    test_duty();
    test_back_to_back();
    test_idle_read_clip();
    test_abort();
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
